scale_scan_ctrl: RTL and testbench
==================================

SCALE_SCAN_CTRL -- requirements
Module: scale_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH_OUT, default 320, output image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT_OUT, default 240, output image height in pixels.
REQ-003 SHALL have parameter READ_LAT, default 1, source-memory read latency in cycles; legal range 1..3.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, on the ports below.
REQ-005 CLK  input  1  system clock; all state updates on its rising edge.
REQ-006 RESET_N  input  1  asynchronous active-low reset.
REQ-007 START  input  1  one-cycle request to begin a full-frame scan.
REQ-008 X_OUT_COORD  output  9  current output column, driven to the nearest-neighbour stage.
REQ-009 Y_OUT_COORD  output  8  current output row, driven to the nearest-neighbour stage.
REQ-010 PIXEL_IN  input  8  pixel returned through the nearest-neighbour stage, valid READ_LAT cycles after the coordinates.
REQ-011 WR_ADDR  output  17  destination-buffer write address.
REQ-012 WR_DATA  output  8  destination-buffer write data.
REQ-013 WR_EN  output  1  write request.
REQ-014 WR_READY  input  1  destination accepts the write this cycle.
REQ-015 BUSY  output  1  high from the cycle after START is accepted until the cycle DONE is high.
REQ-016 DONE  output  1  one-cycle pulse after the last pixel is written.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT, WRITE and FINISH.
REQ-018 IDLE: when START is high, go to ISSUE with X=0, Y=0 and WR_ADDR=0; otherwise remain in IDLE.
REQ-019 ISSUE: drive the coordinates for one cycle, load the wait counter with READ_LAT-1, then go to WAIT.
REQ-020 WAIT: decrement the counter each cycle; at 0, capture PIXEL_IN into WR_DATA and go to WRITE.
REQ-021 WRITE: assert WR_EN and hold WR_ADDR and WR_DATA stable until a cycle in which WR_READY is high.
REQ-022 On acceptance, if the pixel is not the last: advance the counters and go to ISSUE; if it is the last: go to FINISH.
REQ-023 FINISH: assert DONE for exactly one cycle, then go to IDLE.
REQ-024 X_OUT_COORD and Y_OUT_COORD SHALL change only on a write acceptance, and are stable through ISSUE, WAIT and WRITE.
REQ-025 Coordinate advance: X+1; at X=IMG_WIDTH_OUT-1, X wraps to 0 and Y increments.
REQ-026 The last pixel is X=IMG_WIDTH_OUT-1, Y=IMG_HEIGHT_OUT-1.
REQ-027 WR_ADDR SHALL equal Y*IMG_WIDTH_OUT+X, maintained as an incrementing counter (no multiplier); 17 bits cover 76800 locations.
REQ-028 START SHALL be ignored in every state other than IDLE.
REQ-029 WR_EN SHALL be low in every state except WRITE.
REQ-030 Throughput with WR_READY held high: one pixel per READ_LAT+2 cycles.
REQ-031 WR_READY low SHALL stall only the WRITE state, with no data loss and no duplicate write.

Reset
REQ-032 While RESET_N is low: state=IDLE and X_OUT_COORD, Y_OUT_COORD, WR_ADDR, WR_DATA, WR_EN, BUSY and DONE are all 0.
REQ-033 Reset asserted mid-frame SHALL abort the scan immediately, with no DONE; a new START after release restarts the frame at (0,0).

Structure
REQ-034 Package scale_pkg SHALL hold: the state enum, the width constants (9, 8, 17, 8), IMG_WIDTH_IN=160 and the default output dimensions.
REQ-035 The X, Y and WR_ADDR counters SHALL be one sub-module, scan_counter, with inputs clear and advance and outputs x, y, addr and last.

Verification
REQ-036 Reset, then START with WR_READY=1 and READ_LAT=1 -> 76800 writes, one every 3 cycles, at WR_ADDR 0..76799 in order; DONE pulses once.
REQ-037 Source model returns PIXEL=(addr&0xFF), using R_ADDR=(Y>>1)*160+(X>>1) -> write at (X=5,Y=3), address 965, has data (160+2)&0xFF=162.
REQ-038 Hold WR_READY low for 10 cycles during pixel (319,0) -> WR_EN held for 11 cycles with WR_ADDR=319 stable; the next write is (0,1) at address 320.
REQ-039 Pulse START again mid-frame -> ignored; the scan order is unchanged and exactly one DONE occurs.
REQ-040 Assert RESET_N low at pixel 1000 -> all outputs 0 asynchronously and no DONE; START after release -> the first write is address 0.
REQ-041 READ_LAT=3 -> WR_DATA equals the PIXEL_IN sampled 3 cycles after ISSUE; pixel period is 5 cycles.

Source files
------------

// File: rtl/scale_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scale_pkg                                                             |
// | Shared widths, image dimensions and scan FSM states for the scaler.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package scale_pkg;

   localparam int c_x_w    = 9;
   localparam int c_y_w    = 8;
   localparam int c_addr_w = 17;
   localparam int c_pix_w  = 8;

   localparam int c_img_width_in       = 160;
   localparam int c_img_width_out_def  = 320;
   localparam int c_img_height_out_def = 240;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/scan_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scan_counter                                                          |
// | Raster X/Y counters with a linear write address kept alongside.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module scan_counter
   import scale_pkg::*;
#(
   parameter int IMG_WIDTH_OUT  = c_img_width_out_def,
   parameter int IMG_HEIGHT_OUT = c_img_height_out_def
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                advance,
   output logic [c_x_w-1:0]    x,
   output logic [c_y_w-1:0]    y,
   output logic [c_addr_w-1:0] addr,
   output logic                last
);

   localparam logic [c_x_w-1:0] c_x_last = c_x_w'(IMG_WIDTH_OUT - 1);
   localparam logic [c_y_w-1:0] c_y_last = c_y_w'(IMG_HEIGHT_OUT - 1);

   logic [c_x_w-1:0]    r_x;
   logic [c_y_w-1:0]    r_y;
   logic [c_addr_w-1:0] r_addr;

   // Address tracks Y*width+X by counting in raster order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else if (clear) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else if (advance) begin
         r_addr <= r_addr + 1'b1;
         if (r_x == c_x_last) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   assign x    = r_x;
   assign y    = r_y;
   assign addr = r_addr;
   assign last = (r_x == c_x_last) && (r_y == c_y_last);

endmodule
`default_nettype wire

// File: rtl/scale_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scale_scan_ctrl                                                       |
// | Walks the output frame, fetches each pixel and writes it out.         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module scale_scan_ctrl
   import scale_pkg::*;
#(
   parameter int IMG_WIDTH_OUT  = c_img_width_out_def,
   parameter int IMG_HEIGHT_OUT = c_img_height_out_def,
   parameter int READ_LAT       = 1
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                START,
   output logic [c_x_w-1:0]    X_OUT_COORD,
   output logic [c_y_w-1:0]    Y_OUT_COORD,
   input  logic [c_pix_w-1:0]  PIXEL_IN,
   output logic [c_addr_w-1:0] WR_ADDR,
   output logic [c_pix_w-1:0]  WR_DATA,
   output logic                WR_EN,
   input  logic                WR_READY,
   output logic                BUSY,
   output logic                DONE
);

   // READ_LAT is 1..3, so the wait count fits in two bits.
   localparam logic [1:0] c_wait_init = 2'(READ_LAT - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [1:0]           r_wait_cnt;
   logic [c_pix_w-1:0]   r_wr_data;
   logic                 w_clear;
   logic                 w_advance;
   logic                 w_capture;
   logic                 w_last;

   scan_counter #(
      .IMG_WIDTH_OUT  (IMG_WIDTH_OUT),
      .IMG_HEIGHT_OUT (IMG_HEIGHT_OUT)
   ) u_scan_counter (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .clear   (w_clear),
      .advance (w_advance),
      .x       (X_OUT_COORD),
      .y       (Y_OUT_COORD),
      .addr    (WR_ADDR),
      .last    (w_last)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wait_cnt <= '0;
         r_wr_data  <= '0;
      end else begin
         if (r_state == ST_ISSUE) begin
            r_wait_cnt <= c_wait_init;
         end else if ((r_state == ST_WAIT) && (r_wait_cnt != 2'd0)) begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
         end
         if (w_capture) begin
            r_wr_data <= PIXEL_IN;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_advance   = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_wait_cnt == 2'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Coordinates stay put on the final pixel; the next START clears them.
            if (WR_READY) begin
               if (w_last) begin
                  w_state_nxt = ST_FINISH;
               end else begin
                  w_advance   = 1'b1;
                  w_state_nxt = ST_ISSUE;
               end
            end
         end
         ST_FINISH: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign WR_DATA = r_wr_data;
   assign WR_EN   = (r_state == ST_WRITE);
   assign BUSY    = (r_state != ST_IDLE);
   assign DONE    = (r_state == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_scale_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_scale_scan_ctrl                                                    |
// | Directed bench: 320x4 frame at READ_LAT=1 and 16x4 frame at 3.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_scale_scan_ctrl;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;

   logic        a_start = 1'b0, a_ready = 1'b1;
   logic [8:0]  a_x;
   logic [7:0]  a_y, a_data, a_pipe = 8'd0;
   logic [16:0] a_addr;
   logic        a_wr_en, a_busy, a_done;

   logic        b_start = 1'b0, b_ready = 1'b1;
   logic [8:0]  b_x;
   logic [7:0]  b_y, b_data;
   logic [7:0]  b_pipe [3];
   logic [16:0] b_addr;
   logic        b_wr_en, b_busy, b_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   scale_scan_ctrl #(.IMG_WIDTH_OUT(320), .IMG_HEIGHT_OUT(4), .READ_LAT(1)) u_dut_a (
      .CLK(CLK), .RESET_N(RESET_N), .START(a_start),
      .X_OUT_COORD(a_x), .Y_OUT_COORD(a_y), .PIXEL_IN(a_pipe),
      .WR_ADDR(a_addr), .WR_DATA(a_data), .WR_EN(a_wr_en), .WR_READY(a_ready),
      .BUSY(a_busy), .DONE(a_done)
   );

   scale_scan_ctrl #(.IMG_WIDTH_OUT(16), .IMG_HEIGHT_OUT(4), .READ_LAT(3)) u_dut_b (
      .CLK(CLK), .RESET_N(RESET_N), .START(b_start),
      .X_OUT_COORD(b_x), .Y_OUT_COORD(b_y), .PIXEL_IN(b_pipe[2]),
      .WR_ADDR(b_addr), .WR_DATA(b_data), .WR_EN(b_wr_en), .WR_READY(b_ready),
      .BUSY(b_busy), .DONE(b_done)
   );

   // Source image: pixel value is the low byte of its 160-wide source address.
   function automatic logic [7:0] src_pix(input int x, input int y);
      int r;
      r = (y >> 1) * 160 + (x >> 1);
      return r[7:0];
   endfunction

   always @(posedge CLK) begin
      a_pipe    <= src_pix(int'(a_x), int'(a_y));
      b_pipe[0] <= src_pix(int'(b_x), int'(b_y));
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end

   task automatic do_reset;
      @(negedge CLK) RESET_N = 1'b0;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_reset;
      RESET_N = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({a_x, a_y, a_addr, a_data} !== 42'd0) begin
         n_fail++;
         $display("FAIL reset_a_data: got x=%0d y=%0d addr=%0d data=%0d, want all 0", a_x, a_y, a_addr, a_data);
      end
      n_checks++;
      if ({a_wr_en, a_busy, a_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_a_ctrl: got wr_en/busy/done=%b, want 000", {a_wr_en, a_busy, a_done});
      end
      n_checks++;
      if ({b_x, b_y, b_addr, b_data, b_wr_en, b_busy, b_done} !== 45'd0) begin
         n_fail++;
         $display("FAIL reset_b: got x=%0d y=%0d addr=%0d ctrl=%b, want all 0", b_x, b_y, b_addr, {b_wr_en, b_busy, b_done});
      end
      RESET_N = 1'b1;
      repeat (4) @(negedge CLK);
      n_checks++;
      if ({a_wr_en, a_busy, a_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_no_start: got wr_en/busy/done=%b, want 000", {a_wr_en, a_busy, a_done});
      end
   endtask

   task automatic test_full_frame;
      int cyc, wr_cnt, done_cyc, extra, ex, ey;
      a_ready = 1'b1;
      @(negedge CLK) a_start = 1'b1;
      @(negedge CLK) a_start = 1'b0;
      n_checks++;
      if (a_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_busy: got busy=%b, want 1", a_busy);
      end
      cyc = 1; wr_cnt = 0; done_cyc = 0;
      while (done_cyc == 0 && cyc < 5000) begin
         @(negedge CLK); cyc++;
         if (a_wr_en) begin
            ex = wr_cnt % 320; ey = wr_cnt / 320;
            n_checks++;
            if ({a_addr, a_x, a_y, a_data} !== {17'(wr_cnt), 9'(ex), 8'(ey), src_pix(ex, ey)}) begin
               n_fail++;
               $display("FAIL frame_write %0d: got addr=%0d x=%0d y=%0d data=%0d, want addr=%0d x=%0d y=%0d data=%0d",
                        wr_cnt, a_addr, a_x, a_y, a_data, wr_cnt, ex, ey, src_pix(ex, ey));
            end
            n_checks++;
            if (cyc !== 3 + 3 * wr_cnt) begin
               n_fail++;
               $display("FAIL frame_period %0d: got cycle %0d, want %0d", wr_cnt, cyc, 3 + 3 * wr_cnt);
            end
            if (wr_cnt == 965) begin
               n_checks++;
               if ({a_x, a_y, a_data} !== {9'd5, 8'd3, 8'd162}) begin
                  n_fail++;
                  $display("FAIL pixel_965: got x=%0d y=%0d data=%0d, want x=5 y=3 data=162", a_x, a_y, a_data);
               end
            end
            wr_cnt++;
         end
         if (a_done) done_cyc = cyc;
      end
      n_checks++;
      if (wr_cnt !== 1280) begin
         n_fail++;
         $display("FAIL frame_count: got %0d writes, want 1280", wr_cnt);
      end
      n_checks++;
      if (done_cyc !== 3841) begin
         n_fail++;
         $display("FAIL frame_done_cycle: got %0d (0 = none), want 3841", done_cyc);
      end
      extra = 0;
      repeat (5) begin
         @(negedge CLK);
         if (a_done || a_busy) extra++;
      end
      n_checks++;
      if (extra !== 0) begin
         n_fail++;
         $display("FAIL frame_after_done: got %0d cycles with done/busy, want 0", extra);
      end
   endtask

   task automatic test_stall;
      int en_cnt, stall_left, guard;
      bit got_next;
      a_ready = 1'b1;
      @(negedge CLK) a_start = 1'b1;
      @(negedge CLK) a_start = 1'b0;
      en_cnt = 0; stall_left = 10; guard = 0; got_next = 1'b0;
      while (!got_next && guard < 3000) begin
         @(negedge CLK); guard++;
         if (a_wr_en && a_addr == 17'd319) begin
            en_cnt++;
            n_checks++;
            if ({a_x, a_y, a_data} !== {9'd319, 8'd0, 8'd159}) begin
               n_fail++;
               $display("FAIL stall_hold: got x=%0d y=%0d data=%0d, want x=319 y=0 data=159", a_x, a_y, a_data);
            end
            if (stall_left > 0) begin
               a_ready = 1'b0;
               stall_left--;
            end else begin
               a_ready = 1'b1;
            end
         end else if (a_wr_en && en_cnt > 0) begin
            got_next = 1'b1;
            n_checks++;
            if ({a_addr, a_x, a_y, a_data} !== {17'd320, 9'd0, 8'd1, 8'd0}) begin
               n_fail++;
               $display("FAIL stall_next: got addr=%0d x=%0d y=%0d data=%0d, want addr=320 x=0 y=1 data=0",
                        a_addr, a_x, a_y, a_data);
            end
         end
      end
      a_ready = 1'b1;
      n_checks++;
      if (en_cnt !== 11) begin
         n_fail++;
         $display("FAIL stall_wr_en_len: got %0d cycles, want 11", en_cnt);
      end
      n_checks++;
      if (got_next !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_timeout: got no write after pixel 319, want address 320");
      end
   endtask

   task automatic test_restart_ignored;
      int cyc, wr_cnt, done_cnt;
      a_ready = 1'b1;
      @(negedge CLK) a_start = 1'b1;
      @(negedge CLK) a_start = 1'b0;
      cyc = 1; wr_cnt = 0; done_cnt = 0;
      while (done_cnt == 0 && cyc < 5000) begin
         @(negedge CLK); cyc++;
         a_start = 1'b0;
         if (a_wr_en) begin
            n_checks++;
            if (a_addr !== 17'(wr_cnt)) begin
               n_fail++;
               $display("FAIL restart_order: got addr=%0d, want %0d", a_addr, wr_cnt);
            end
            if (wr_cnt == 100) a_start = 1'b1;
            wr_cnt++;
         end
         if (cyc == 2000 || cyc == 2998) a_start = 1'b1;
         if (a_done) done_cnt++;
      end
      a_start = 1'b0;
      n_checks++;
      if (cyc !== 3841 || wr_cnt !== 1280) begin
         n_fail++;
         $display("FAIL restart_timing: got done cycle %0d with %0d writes, want 3841 with 1280", cyc, wr_cnt);
      end
      repeat (6) begin
         @(negedge CLK);
         if (a_done) done_cnt++;
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL restart_done_count: got %0d, want 1", done_cnt);
      end
   endtask

   task automatic test_reset_mid_frame;
      int guard, done_cnt, cyc;
      a_ready = 1'b1;
      @(negedge CLK) a_start = 1'b1;
      @(negedge CLK) a_start = 1'b0;
      guard = 0;
      while (!(a_wr_en && a_addr == 17'd1000) && guard < 4000) begin
         @(negedge CLK); guard++;
      end
      n_checks++;
      if (a_addr !== 17'd1000) begin
         n_fail++;
         $display("FAIL abort_reach: got addr=%0d, want 1000", a_addr);
      end
      RESET_N = 1'b0;
      #1;
      n_checks++;
      if ({a_x, a_y, a_addr, a_data, a_wr_en, a_busy, a_done} !== 45'd0) begin
         n_fail++;
         $display("FAIL abort_async: got x=%0d y=%0d addr=%0d data=%0d ctrl=%b, want all 0",
                  a_x, a_y, a_addr, a_data, {a_wr_en, a_busy, a_done});
      end
      done_cnt = 0;
      repeat (3) begin
         @(negedge CLK);
         if (a_done) done_cnt++;
      end
      RESET_N = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         if (a_done || a_busy) done_cnt++;
      end
      n_checks++;
      if (done_cnt !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d done/busy cycles, want 0", done_cnt);
      end
      @(negedge CLK) a_start = 1'b1;
      @(negedge CLK) a_start = 1'b0;
      cyc = 1;
      while (!a_wr_en && cyc < 20) begin
         @(negedge CLK); cyc++;
      end
      n_checks++;
      if ({a_addr, a_x, a_y, a_data} !== 42'd0 || cyc !== 3) begin
         n_fail++;
         $display("FAIL abort_restart: got addr=%0d x=%0d y=%0d data=%0d at cycle %0d, want all 0 at cycle 3",
                  a_addr, a_x, a_y, a_data, cyc);
      end
   endtask

   task automatic test_read_lat3;
      int cyc, wr_cnt, done_cyc, ex, ey;
      b_ready = 1'b1;
      @(negedge CLK) b_start = 1'b1;
      @(negedge CLK) b_start = 1'b0;
      cyc = 1; wr_cnt = 0; done_cyc = 0;
      while (done_cyc == 0 && cyc < 1000) begin
         @(negedge CLK); cyc++;
         if (b_wr_en) begin
            ex = wr_cnt % 16; ey = wr_cnt / 16;
            n_checks++;
            if ({b_addr, b_x, b_y, b_data} !== {17'(wr_cnt), 9'(ex), 8'(ey), src_pix(ex, ey)} ||
                cyc !== 5 + 5 * wr_cnt) begin
               n_fail++;
               $display("FAIL lat3_write %0d: got addr=%0d x=%0d y=%0d data=%0d cycle=%0d, want addr=%0d x=%0d y=%0d data=%0d cycle=%0d",
                        wr_cnt, b_addr, b_x, b_y, b_data, cyc, wr_cnt, ex, ey, src_pix(ex, ey), 5 + 5 * wr_cnt);
            end
            if (wr_cnt == 53) begin
               n_checks++;
               if ({b_x, b_y, b_data} !== {9'd5, 8'd3, 8'd162}) begin
                  n_fail++;
                  $display("FAIL lat3_pixel_53: got x=%0d y=%0d data=%0d, want x=5 y=3 data=162", b_x, b_y, b_data);
               end
            end
            wr_cnt++;
         end
         if (b_done) done_cyc = cyc;
      end
      n_checks++;
      if (wr_cnt !== 64 || done_cyc !== 321) begin
         n_fail++;
         $display("FAIL lat3_frame: got %0d writes, done at %0d, want 64 writes, done at 321", wr_cnt, done_cyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_full_frame;
      test_stall;
      do_reset;
      test_restart_ignored;
      test_reset_mid_frame;
      test_read_lat3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
